// File: rtl/gs_row_sequencer.sv
// gs_row_sequencer: loads an NxN int8 system, runs Gauss-Seidel sweeps row by row on a one-shot core, streams x out.
// Optional GS_EARLY_EXIT_EN: stop once a sweep's max |dx| <= TOL and report sweeps executed on o_sweeps.
module gs_row_sequencer #(
  parameter int N = 8,
  parameter int ITER = 16
`ifdef GS_EARLY_EXIT_EN
  , parameter logic [31:0] TOL = 32'h0000_0100
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic                  i_row_valid,
  output logic                  o_row_ready,
  input  logic [N*8-1:0]        i_row,
  input  logic [7:0]            i_b,
  input  logic [31:0]           i_recip,
  output logic                  o_core_reset,
  output logic                  o_core_valid,
  output logic [(N-1)*8-1:0]    o_core_a,
  output logic [7:0]            o_core_b,
  output logic [31:0]           o_core_a_down,
  output logic [(N-1)*32-1:0]   o_core_x,
  input  logic                  i_core_valid,
  input  logic [31:0]           i_core_x_next,
  output logic                  o_x_valid,
  output logic [$clog2(N)-1:0]  o_x_idx,
  output logic [31:0]           o_x,
`ifdef GS_EARLY_EXIT_EN
  output logic [7:0]            o_sweeps,
`endif
  output logic                  o_done
);
  localparam int RW = $clog2(N);
  localparam logic [RW-1:0] LAST = RW'(N-1);
  localparam logic [7:0] SLAST = 8'(ITER-1);
  typedef enum logic [2:0] {IDLE, LOAD, CRST, ISSUE, WAIT, WB, OUT, DONE} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic [7:0] sweep_q, sweep_d;
  logic [N*8-1:0] row_q [N], row_d [N];
  logic [7:0] b_q [N], b_d [N];
  logic [31:0] recip_q [N], recip_d [N];
  logic [31:0] x_q [N], x_d [N];
  logic [(N-1)*8-1:0] a_q, a_d;
  logic [7:0] cb_q, cb_d;
  logic [31:0] ad_q, ad_d;
  logic [(N-1)*32-1:0] cx_q, cx_d;
  logic last, conv;
  // Slot j of row r maps to column j, or j+1 once past the diagonal.
  function automatic logic [RW-1:0] col(input int j, input logic [RW-1:0] r);
    return (j < int'(r)) ? RW'(j) : RW'(j + 1);
  endfunction
  assign last = r_q == LAST;
`ifdef GS_EARLY_EXIT_EN
  logic [32:0] max_q, max_d, dx, mx;
  logic [7:0] sw_q, sw_d;
  logic signed [32:0] diff;
  assign diff = $signed({i_core_x_next[31], i_core_x_next}) - $signed({x_q[r_q][31], x_q[r_q]});
  assign dx = diff[32] ? 33'(-diff) : 33'(diff);
  assign mx = (dx > max_q) ? dx : max_q;
  assign conv = mx <= {1'b0, TOL};
  assign o_sweeps = sw_q;
`else
  assign conv = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    r_d = r_q;
    sweep_d = sweep_q;
    row_d = row_q;
    b_d = b_q;
    recip_d = recip_q;
    x_d = x_q;
    a_d = a_q;
    cb_d = cb_q;
    ad_d = ad_q;
    cx_d = cx_q;
`ifdef GS_EARLY_EXIT_EN
    max_d = max_q;
    sw_d = sw_q;
`endif
    case (state_q)
      IDLE: if (i_start) begin
        state_d = LOAD;
        r_d = '0;
      end
      LOAD: if (i_row_valid) begin
        row_d[r_q] = i_row;
        b_d[r_q] = i_b;
        recip_d[r_q] = i_recip;
        r_d = last ? '0 : r_q + 1'b1;
        sweep_d = last ? '0 : sweep_q;
        state_d = last ? CRST : LOAD;
`ifdef GS_EARLY_EXIT_EN
        max_d = '0;
`endif
      end
      CRST: begin
        for (int j = 0; j < N - 1; j++) begin
          a_d[(N-2-j)*8 +: 8] = row_q[r_q][(N-1-int'(col(j, r_q)))*8 +: 8];
          cx_d[(N-2-j)*32 +: 32] = x_q[col(j, r_q)];
        end
        cb_d = b_q[r_q];
        ad_d = recip_q[r_q];
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: state_d = i_core_valid ? WB : WAIT;
      WB: begin
        x_d[r_q] = i_core_x_next;
        r_d = last ? '0 : r_q + 1'b1;
        state_d = (last && (sweep_q == SLAST || conv)) ? OUT : CRST;
        sweep_d = (last && state_d == CRST) ? sweep_q + 8'd1 : sweep_q;
`ifdef GS_EARLY_EXIT_EN
        max_d = (last && state_d == CRST) ? '0 : mx;
        sw_d = (state_d == OUT) ? sweep_q + 8'd1 : sw_q;
`endif
      end
      OUT: begin
        r_d = last ? '0 : r_q + 1'b1;
        state_d = last ? DONE : OUT;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      r_q <= '0;
      sweep_q <= '0;
      a_q <= '0;
      cb_q <= '0;
      ad_q <= '0;
      cx_q <= '0;
      for (int i = 0; i < N; i++) begin
        row_q[i] <= '0;
        b_q[i] <= '0;
        recip_q[i] <= '0;
        x_q[i] <= '0;
      end
`ifdef GS_EARLY_EXIT_EN
      max_q <= '0;
      sw_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      sweep_q <= sweep_d;
      row_q <= row_d;
      b_q <= b_d;
      recip_q <= recip_d;
      x_q <= x_d;
      a_q <= a_d;
      cb_q <= cb_d;
      ad_q <= ad_d;
      cx_q <= cx_d;
`ifdef GS_EARLY_EXIT_EN
      max_q <= max_d;
      sw_q <= sw_d;
`endif
    end
  end
  assign o_row_ready = state_q == LOAD;
  assign o_core_reset = ~i_reset_n | (state_q == CRST);
  assign o_core_valid = state_q == ISSUE;
  assign o_core_a = a_q;
  assign o_core_b = cb_q;
  assign o_core_a_down = ad_q;
  assign o_core_x = cx_q;
  assign o_x_valid = state_q == OUT;
  assign o_x_idx = (state_q == OUT) ? r_q : '0;
  assign o_x = (state_q == OUT) ? x_q[r_q] : '0;
  assign o_done = state_q == DONE;
endmodule

// File: tb/tb_gs_row_sequencer.sv
// tb_gs_row_sequencer: random GS systems against an array-based sweep model, with a one-shot core stub.
module tb_gs_row_sequencer;
  localparam int N = 8;
  localparam int ITER = 3;
  localparam logic [31:0] TOL = 32'h0000_0100;
  typedef logic signed [31:0] vec_t [N];
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_n = 0, i_start = 0, i_row_valid = 0, o_row_ready;
  logic [N*8-1:0] i_row = '0;
  logic [7:0] i_b = '0;
  logic [31:0] i_recip = '0;
  logic o_core_reset, o_core_valid, o_x_valid, o_done;
  logic [(N-1)*8-1:0] o_core_a;
  logic [7:0] o_core_b;
  logic [31:0] o_core_a_down, o_x;
  logic [(N-1)*32-1:0] o_core_x;
  logic i_core_valid = 0;
  logic [31:0] i_core_x_next = '0;
  logic [2:0] o_x_idx;
`ifdef GS_EARLY_EXIT_EN
  logic [7:0] o_sweeps;
  logic [7:0] got_sweeps;
`endif
  gs_row_sequencer #(.N(N), .ITER(ITER)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(i_start), .i_row_valid(i_row_valid),
    .o_row_ready(o_row_ready), .i_row(i_row), .i_b(i_b), .i_recip(i_recip),
    .o_core_reset(o_core_reset), .o_core_valid(o_core_valid), .o_core_a(o_core_a),
    .o_core_b(o_core_b), .o_core_a_down(o_core_a_down), .o_core_x(o_core_x),
    .i_core_valid(i_core_valid), .i_core_x_next(i_core_x_next), .o_x_valid(o_x_valid),
    .o_x_idx(o_x_idx), .o_x(o_x),
`ifdef GS_EARLY_EXIT_EN
    .o_sweeps(o_sweeps),
`endif
    .o_done(o_done));
  int tests = 0, fails = 0;
  logic signed [7:0] ma [N][N];
  logic signed [7:0] mb [N];
  logic [31:0] mr [N];
  vec_t model_x;
  int m_sweeps;
  logic [31:0] got_x [N];
  int got_done, got_cnt, order_err;
  logic timed_out;
  function automatic logic [31:0] fx(logic signed [7:0] b, logic [31:0] recip, longint sum);
    longint acc;
    acc = (longint'(b) <<< 24) - sum;
    return 32'((acc * longint'($signed(recip))) >>> 30);
  endfunction
  function automatic logic [31:0] ref_row(int r, vec_t xv);
    longint s = 0;
    for (int c = 0; c < N; c++) if (c != r) s += longint'(ma[r][c]) * longint'(xv[c]);
    return fx(mb[r], mr[r], s);
  endfunction
  // Core stub: one-shot, samples operands on o_core_valid, answers after core_delay cycles and holds.
  int core_delay = 2, cnt = 0, n_issue = 0, n_crst = 0, stab_err = 0, pack_target = -1;
  logic busy = 0;
  logic [(N-1)*8-1:0] sa, pk_a;
  logic [7:0] sb;
  logic [31:0] sd;
  logic [(N-1)*32-1:0] sx, pk_x;
  function automatic longint stub_sum(logic [(N-1)*8-1:0] a, logic [(N-1)*32-1:0] x);
    longint s = 0;
    for (int j = 0; j < N - 1; j++)
      s += longint'($signed(a[(N-2-j)*8 +: 8])) * longint'($signed(x[(N-2-j)*32 +: 32]));
    return s;
  endfunction
  always @(posedge clk) begin
    if (o_core_reset) begin
      busy <= 0;
      i_core_valid <= 0;
      if (rst_n) n_crst <= n_crst + 1;
    end else begin
      if ((busy || i_core_valid) && (o_core_a !== sa || o_core_b !== sb || o_core_a_down !== sd || o_core_x !== sx))
        stab_err <= stab_err + 1;
      if (o_core_valid) begin
        sa <= o_core_a; sb <= o_core_b; sd <= o_core_a_down; sx <= o_core_x;
        cnt <= core_delay; busy <= 1; n_issue <= n_issue + 1;
        if (n_issue == pack_target) begin pk_a <= o_core_a; pk_x <= o_core_x; end
      end else if (busy) begin
        if (cnt == 0) begin
          busy <= 0;
          i_core_valid <= 1;
          i_core_x_next <= fx(sb, sd, stub_sum(sa, sx));
        end else cnt <= cnt - 1;
      end
    end
  end
  task automatic model_solve();
    longint d, md;
    logic signed [31:0] nx;
    m_sweeps = 0;
    for (int s = 0; s < ITER; s++) begin
      md = 0;
      for (int r = 0; r < N; r++) begin
        nx = ref_row(r, model_x);
        d = longint'(nx) - longint'(model_x[r]);
        if (d < 0) d = -d;
        if (d > md) md = d;
        model_x[r] = nx;
      end
      m_sweeps = s + 1;
`ifdef GS_EARLY_EXIT_EN
      if (md <= longint'(TOL)) break;
`endif
    end
  endtask
  task automatic gen_random();
    int dg;
    for (int r = 0; r < N; r++) begin
      dg = $urandom_range(30, 60);
      for (int c = 0; c < N; c++) ma[r][c] = (c == r) ? 8'(dg) : 8'($urandom_range(0, 6) - 3);
      mb[r] = 8'($urandom_range(0, 255));
      mr[r] = 32'((64'd1 << 30) / dg);
    end
  endtask
  task automatic start_and_load();
    int w;
    @(negedge clk); i_start = 1;
    @(negedge clk); i_start = 0;
    for (int r = 0; r < N; r++) begin
      w = 0;
      while (!o_row_ready && w < 50) begin @(negedge clk); w++; end
      if (w == 50) timed_out = 1;
      for (int c = 0; c < N; c++) i_row[(N-1-c)*8 +: 8] = ma[r][c];
      i_b = mb[r]; i_recip = mr[r]; i_row_valid = 1;
      @(negedge clk); i_row_valid = 0;
    end
  endtask
  task automatic run_solve();
    int left = -1;
    timed_out = 0; got_done = 0; got_cnt = 0; order_err = 0;
    start_and_load();
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (o_x_valid) begin
        if (int'(o_x_idx) != got_cnt) order_err++;
        got_x[o_x_idx] = o_x;
        got_cnt++;
      end
      if (o_done) begin
        got_done++;
`ifdef GS_EARLY_EXIT_EN
        got_sweeps = o_sweeps;
`endif
        if (left < 0) left = 5;
      end
      if (left == 0) break;
      if (left > 0) left--;
    end
    if (got_done == 0) timed_out = 1;
  endtask
  task automatic check_solve(string nm);
    tests++; if (timed_out !== 1'b0) begin fails++; $display("FAIL %s timeout: got %b exp 0", nm, timed_out); end
    tests++; if (got_done != 1) begin fails++; $display("FAIL %s done_count: got %0d exp 1", nm, got_done); end
    tests++; if (got_cnt != N || order_err != 0) begin fails++; $display("FAIL %s beats: got %0d/%0d bad exp %0d/0", nm, got_cnt, order_err, N); end
    for (int i = 0; i < N; i++) begin
      tests++;
      if (got_x[i] !== model_x[i]) begin fails++; $display("FAIL %s x[%0d]: got %h exp %h", nm, i, got_x[i], model_x[i]); end
    end
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    tests++; if (o_core_reset !== 1'b1) begin fails++; $display("FAIL rst core_reset: got %b exp 1", o_core_reset); end
    tests++; if ({o_row_ready, o_core_valid, o_x_valid, o_done} !== 4'b0) begin fails++; $display("FAIL rst flags: got %b exp 0000", {o_row_ready, o_core_valid, o_x_valid, o_done}); end
    tests++; if (o_core_a !== '0 || o_core_x !== '0 || o_x !== '0) begin fails++; $display("FAIL rst data: got %h %h %h exp 0", o_core_a, o_core_x, o_x); end
    rst_n = 1;
    for (int i = 0; i < N; i++) model_x[i] = 0;
    @(negedge clk);
    tests++; if (o_core_reset !== 1'b0) begin fails++; $display("FAIL idle core_reset: got %b exp 0", o_core_reset); end
    i_row_valid = 1;
    @(negedge clk);
    tests++; if (o_row_ready !== 1'b0) begin fails++; $display("FAIL idle ready: got %b exp 0", o_row_ready); end
    i_row_valid = 0;
  endtask
  task automatic test_diagonal();
    int bi = n_issue;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) ma[r][c] = (c == r) ? 8'sd2 : 8'sd0;
      mb[r] = 8'sd4; mr[r] = 32'h2000_0000;
    end
    model_solve();
    run_solve();
    check_solve("diag");
    for (int i = 0; i < N; i++) begin
      tests++; if (got_x[i] !== 32'h0200_0000) begin fails++; $display("FAIL diag const x[%0d]: got %h exp 02000000", i, got_x[i]); end
    end
    tests++; if (n_issue - bi != m_sweeps * N) begin fails++; $display("FAIL diag issues: got %0d exp %0d", n_issue - bi, m_sweeps * N); end
`ifdef GS_EARLY_EXIT_EN
    tests++; if (got_sweeps !== 8'd2) begin fails++; $display("FAIL diag sweeps: got %0d exp 2", got_sweeps); end
`endif
  endtask
  task automatic test_gs_order();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) ma[r][c] = (c == r) ? 8'sd1 : 8'sd0;
      mb[r] = 8'sd0; mr[r] = 32'h4000_0000;
    end
    ma[0][0] = 8'sd4; mb[0] = 8'sd4; mr[0] = 32'h1000_0000;
    ma[1][1] = 8'sd4; ma[1][0] = 8'sd1; mb[1] = 8'sd5; mr[1] = 32'h1000_0000;
    model_solve();
    run_solve();
    check_solve("order");
    tests++; if (got_x[0] !== 32'h0100_0000 || got_x[1] !== 32'h0100_0000) begin fails++; $display("FAIL order x01: got %h %h exp 01000000", got_x[0], got_x[1]); end
  endtask
  task automatic test_packing();
    vec_t xt;
    logic [(N-1)*8-1:0] ea;
    gen_random();
    for (int c = 0; c < N; c++) ma[3][c] = (c == 3) ? 8'sd40 : 8'(c + 1);
    mr[3] = 32'((64'd1 << 30) / 40);
    xt = model_x;
    for (int r = 0; r < 3; r++) xt[r] = ref_row(r, xt);
    ea = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd8};
    pack_target = n_issue + 3;
    model_solve();
    run_solve();
    pack_target = -1;
    tests++; if (pk_a !== ea) begin fails++; $display("FAIL pack a: got %h exp %h", pk_a, ea); end
    for (int j = 0; j < N - 1; j++) begin
      tests++;
      if (pk_x[(N-2-j)*32 +: 32] !== xt[(j < 3) ? j : j + 1]) begin
        fails++; $display("FAIL pack x slot%0d: got %h exp %h", j, pk_x[(N-2-j)*32 +: 32], xt[(j < 3) ? j : j + 1]);
      end
    end
    check_solve("pack");
  endtask
  task automatic test_slow_core();
    int bi = n_issue, bc = n_crst, bs = stab_err;
    core_delay = 10;
    gen_random();
    model_solve();
    run_solve();
    check_solve("slow");
    tests++; if (stab_err != bs) begin fails++; $display("FAIL slow stable: got %0d changes exp 0", stab_err - bs); end
    tests++; if (n_issue - bi != m_sweeps * N) begin fails++; $display("FAIL slow issues: got %0d exp %0d", n_issue - bi, m_sweeps * N); end
    tests++; if (n_crst - bc != m_sweeps * N) begin fails++; $display("FAIL slow crst: got %0d exp %0d", n_crst - bc, m_sweeps * N); end
    core_delay = 2;
  endtask
  task automatic test_random();
    for (int t = 0; t < 3; t++) begin
      core_delay = $urandom_range(0, 5);
      gen_random();
      model_solve();
      run_solve();
      check_solve("rand");
    end
    core_delay = 2;
  endtask
  task automatic test_reset_mid();
    int bi = n_issue, k = 0, dn = 0;
    timed_out = 0;
    gen_random();
    start_and_load();
    while (n_issue - bi < 2 * N + 2 && k < 5000) begin @(negedge clk); k++; end
    tests++; if (k == 5000) begin fails++; $display("FAIL mid reach: got %0d issues exp %0d", n_issue - bi, 2 * N + 2); end
    rst_n = 0;
    #1;
    tests++; if (o_core_reset !== 1'b1) begin fails++; $display("FAIL mid core_reset: got %b exp 1", o_core_reset); end
    tests++; if ({o_core_valid, o_x_valid, o_row_ready} !== 3'b0 || o_core_a !== '0) begin fails++; $display("FAIL mid outputs: got %b %h exp 0", {o_core_valid, o_x_valid, o_row_ready}, o_core_a); end
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (o_done) dn++; end
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (o_done) dn++; end
    tests++; if (dn != 0) begin fails++; $display("FAIL mid no_done: got %0d exp 0", dn); end
    for (int i = 0; i < N; i++) model_x[i] = 0;
    gen_random();
    model_solve();
    run_solve();
    check_solve("after_rst");
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_diagonal();
    test_gs_order();
    test_packing();
    test_slow_core();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
